// File: rtl/ysyx_25040109_ifu_pkg.sv
// Shared constants for the instruction fetch unit: FSM encoding, NOP word, reset PC, fault codes.
// Pure definitions; no logic, no latency, no flow control.
package ysyx_25040109_ifu_pkg;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_ACCESS   = 2'b01;
    localparam logic [1:0] FLT_MISALIGN = 2'b10;

endpackage

// File: rtl/ysyx_25040109_pc_next.sv
// Next-PC select: redirect beats sequential advance, otherwise hold. Purely combinational,
// zero latency, no flow control of its own.
module ysyx_25040109_pc_next #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (advance) begin
            pc_next = pc + {{(XLEN-3){1'b0}}, 3'd4};
        end
    end

endmodule

// File: rtl/ysyx_25040109_ifu.sv
// Instruction fetch: one outstanding word read, one held instruction; accept->inst_valid is 2 cycles min.
// Decoder backpressure (inst_ready=0) freezes the held instruction and blocks the next request.
module ysyx_25040109_ifu
    import ysyx_25040109_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [31:0]     mem_resp_data,
    input  logic            mem_resp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [1:0]      inst_fault
);

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic            kill;
    logic            halt;
    logic            pc_aligned;
    logic            req_fire;
    logic            hold_fire;
    logic            advance;

    assign pc_aligned    = (pc[1:0] == 2'b00);
    assign mem_req_valid = (state == S_REQ) & ~rst & ~halt & pc_aligned;
    assign mem_req_addr  = pc;
    assign req_fire      = mem_req_valid & mem_req_ready;
    assign inst_valid    = (state == S_HOLD);
    assign hold_fire     = inst_valid & inst_ready;
    // A misaligned-target fault does not step the PC; the unit parks until redirected.
    assign advance       = hold_fire & (inst_fault != FLT_MISALIGN);

    ysyx_25040109_pc_next #(
        .XLEN(XLEN)
    ) u_pc_next (
        .pc            (pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .advance       (advance),
        .pc_next       (pc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            halt       <= 1'b0;
            inst       <= NOP;
            inst_pc    <= '0;
            inst_fault <= FLT_NONE;
        end else begin
            pc <= pc_nxt;
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        state <= S_WAIT;
                        kill  <= redirect_valid;
                    end else if (!redirect_valid && !halt && !pc_aligned) begin
                        state      <= S_HOLD;
                        inst       <= NOP;
                        inst_pc    <= pc;
                        inst_fault <= FLT_MISALIGN;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        kill <= 1'b0;
                        // A response that was in flight across a redirect belongs to the old path.
                        if (redirect_valid || kill) begin
                            state <= S_REQ;
                        end else begin
                            state      <= S_HOLD;
                            inst       <= mem_resp_err ? NOP : mem_resp_data;
                            inst_pc    <= pc;
                            inst_fault <= mem_resp_err ? FLT_ACCESS : FLT_NONE;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        state <= S_REQ;
                    end else if (inst_ready) begin
                        state <= S_REQ;
                        halt  <= (inst_fault == FLT_MISALIGN);
                    end
                end
                default: state <= S_REQ;
            endcase
            if (redirect_valid) begin
                halt <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_ifu.sv
// Bench for the fetch unit: responder model, instruction scoreboard, table of sequential fetches
// plus directed redirect / fault / reset sequences.
module tb_ysyx_25040109_ifu;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  fault;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          lat;
        int          stall;
        logic        err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_fault;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          resp_lat;
    int          countdown = 0;
    logic [31:0] err_addr;
    logic [31:0] pend_addr;
    logic [31:0] acc_q[$];
    int          acc_cyc_q[$];
    exp_t        exp_q[$];
    vec_t        vecs[4];

    ysyx_25040109_ifu dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .mem_resp_err  (mem_resp_err),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_fault    (inst_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0297;
        return {a[15:0], 16'h0093};
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic err);
        exp_t e;
        e.inst  = err ? 32'h0000_0013 : mem_word(a);
        e.pc    = a;
        e.fault = err ? 2'b01 : 2'b00;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Memory responder: one response per accepted request, resp_lat cycles after acceptance.
    initial begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        mem_resp_err   = 1'b0;
        pend_addr      = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (rst) begin
                countdown = 0;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(pend_addr);
                    mem_resp_err   = (pend_addr == err_addr);
                end
            end
            #1;
            if (mem_req_valid && mem_req_ready) begin
                acc_q.push_back(mem_req_addr);
                acc_cyc_q.push_back(cyc);
                pend_addr = mem_req_addr;
                countdown = resp_lat;
            end
        end
    end

    // Scoreboard: every decoder handshake must match the oldest expected instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && inst_valid && inst_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_inst_handshake");
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_inst", inst, e.inst);
                    chk("sb_inst_pc", inst_pc, e.pc);
                    chk("sb_inst_fault", {30'd0, inst_fault}, {30'd0, e.fault});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic release_hold();
        @(negedge clk);
        inst_ready = 1'b1;
        #3;
        @(negedge clk);
        inst_ready = 1'b0;
        #3;
    endtask

    task automatic expect_req(input string name, input logic [31:0] a, output int ac, output logic saw_v);
        int i = 0;
        saw_v = 1'b0;
        ac    = 0;
        while (acc_q.size() == 0 && i < 50) begin
            if (inst_valid) saw_v = 1'b1;
            @(negedge clk);
            #3;
            i++;
        end
        if (acc_q.size() == 0) begin
            timeout_fail(name);
        end else begin
            chk(name, acc_q.pop_front(), a);
            ac = acc_cyc_q.pop_front();
        end
    endtask

    task automatic wait_valid(input string name, output int vc);
        int i = 0;
        while (!inst_valid && i < 50) begin
            @(negedge clk);
            #3;
            i++;
        end
        vc = cyc;
        if (!inst_valid) timeout_fail(name);
    endtask

    task automatic stall_check(input string name, input int n, input exp_t e);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #3;
            chk({name, "_flags"}, {30'd0, inst_valid, mem_req_valid}, 32'd2);
            chk({name, "_inst"}, inst, e.inst);
            chk({name, "_pc"}, inst_pc, e.pc);
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        #3;
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
    endtask

    initial begin
        int   ac;
        int   vc;
        logic sv;
        exp_t e;

        vecs[0] = '{32'h8000_0004, 1, 0, 1'b0};
        vecs[1] = '{32'h8000_0008, 3, 2, 1'b0};
        vecs[2] = '{32'h8000_000C, 1, 1, 1'b1};
        vecs[3] = '{32'h8000_0010, 2, 0, 1'b0};

        rst            = 1'b1;
        mem_req_ready  = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        resp_lat       = 1;
        err_addr       = 32'h0000_0001;

        repeat (3) @(negedge clk);
        #3;
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_fault", {30'd0, inst_fault}, 32'd0);

        // First fetch after reset, then a 5-cycle decoder stall.
        @(negedge clk);
        rst = 1'b0;
        #3;
        e = model(32'h8000_0000, 1'b0);
        exp_q.push_back(e);
        expect_req("first_req_addr", 32'h8000_0000, ac, sv);
        wait_valid("first_valid", vc);
        chk("first_latency", vc - ac, 32'd2);
        chk("first_inst_pc", inst_pc, 32'h8000_0000);
        stall_check("stall5", 5, e);
        chk("stall_no_req", acc_q.size(), 32'd0);

        foreach (vecs[i]) begin
            resp_lat = vecs[i].lat;
            err_addr = vecs[i].err ? vecs[i].addr : 32'h0000_0001;
            e = model(vecs[i].addr, vecs[i].err);
            exp_q.push_back(e);
            release_hold();
            expect_req("seq_addr", vecs[i].addr, ac, sv);
            wait_valid("seq_valid", vc);
            chk("seq_latency", vc - ac, vecs[i].lat + 1);
            stall_check("seq_hold", vecs[i].stall, e);
        end
        err_addr = 32'h0000_0001;

        // Redirect while the fetch of 0x8000_0014 is outstanding.
        resp_lat = 4;
        release_hold();
        expect_req("wait_req_addr", 32'h8000_0014, ac, sv);
        resp_lat = 1;
        redirect_to(32'h8000_0100);
        expect_req("redir_wait_addr", 32'h8000_0100, ac, sv);
        chk("stale_no_valid", {31'd0, sv}, 32'd0);
        wait_valid("redir_valid", vc);
        chk("redir_inst_pc", inst_pc, 32'h8000_0100);
        chk("redir_inst", inst, mem_word(32'h8000_0100));

        // Redirect in S_HOLD with inst_ready high in the same cycle drops the instruction.
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        inst_ready     = 1'b1;
        #3;
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #3;
        chk("hold_drop_valid", {31'd0, inst_valid}, 32'd0);
        expect_req("hold_drop_addr", 32'h8000_0200, ac, sv);
        wait_valid("t4_valid", vc);

        // Misaligned target: no request, fault presented, then halt until redirected.
        redirect_to(32'h8000_0102);
        chk("misalign_no_req", {31'd0, mem_req_valid}, 32'd0);
        exp_q.push_back('{32'h0000_0013, 32'h8000_0102, 2'b10});
        wait_valid("misalign_valid", vc);
        chk("misalign_fault", {30'd0, inst_fault}, 32'd2);
        chk("misalign_no_acc", acc_q.size(), 32'd0);
        release_hold();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #3;
            chk("halt_idle", {30'd0, inst_valid, mem_req_valid}, 32'd0);
        end
        chk("halt_no_acc", acc_q.size(), 32'd0);
        resp_lat = 3;
        redirect_to(32'h8000_0300);
        expect_req("resume_addr", 32'h8000_0300, ac, sv);

        // Reset while waiting on memory.
        @(negedge clk);
        rst = 1'b1;
        #3;
        chk("midrst_req_low", {31'd0, mem_req_valid}, 32'd0);
        resp_lat = 1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("midrst_inst", inst, 32'h0000_0013);
        chk("midrst_inst_pc", inst_pc, 32'h0);
        chk("midrst_fault", {30'd0, inst_fault}, 32'd0);
        e = model(32'h8000_0000, 1'b0);
        exp_q.push_back(e);
        expect_req("midrst_first_addr", 32'h8000_0000, ac, sv);
        wait_valid("midrst_valid", vc);
        chk("midrst_latency", vc - ac, 32'd2);
        release_hold();

        // PC wrap from the top of the address space.
        expect_req("after_rst_addr", 32'h8000_0004, ac, sv);
        wait_valid("wrap_pre_valid", vc);
        redirect_to(32'hFFFF_FFFC);
        expect_req("wrap_addr", 32'hFFFF_FFFC, ac, sv);
        exp_q.push_back(model(32'hFFFF_FFFC, 1'b0));
        wait_valid("wrap_valid", vc);
        release_hold();
        expect_req("wrap_next_addr", 32'h0000_0000, ac, sv);
        wait_valid("wrap_last_valid", vc);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("no_extra_requests", acc_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
